// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: I-cache reads and D-cache reads/writes share one memory port.
// Define ARB_RR_EN for round-robin tie-break; otherwise D-side has fixed priority.
module mem_arbiter #(
   parameter int ADDR_W = 28,
   parameter int DATA_W = 128
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_read,
   input  logic [ADDR_W-1:0] i_addr,
   output logic [DATA_W-1:0] i_rdata,
   output logic              i_ready,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_ready,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready
);

   typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY, RECOVER} state_t;

   state_t              r_state, w_next_state;
   logic                r_mem_read, w_mem_read;
   logic                r_mem_write, w_mem_write;
   logic [ADDR_W-1:0]   r_mem_addr, w_mem_addr;
   logic [DATA_W-1:0]   r_mem_wdata, w_mem_wdata;
   logic                w_d_req;
   logic                w_grant_d;
   logic                w_grant_i;

   assign w_d_req = d_read | d_write;

`ifdef ARB_RR_EN
   // Last-grant memory: 1 means D was granted last; resets to I so the first tie goes to D.
   logic r_last_d;

   always_comb begin
      if (w_d_req && i_read) w_grant_d = ~r_last_d;
      else                   w_grant_d = w_d_req;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_last_d <= 1'b0;
      else if (r_state == IDLE && (w_d_req || i_read))
         r_last_d <= w_grant_d;
   end
`else
   assign w_grant_d = w_d_req;
`endif

   assign w_grant_i = i_read & ~w_grant_d;

   always_comb begin
      w_next_state = r_state;
      w_mem_read   = r_mem_read;
      w_mem_write  = r_mem_write;
      w_mem_addr   = r_mem_addr;
      w_mem_wdata  = r_mem_wdata;
      case (r_state)
         IDLE: begin
            if (w_grant_d) begin
               w_next_state = D_BUSY;
               w_mem_write  = d_write;
               w_mem_read   = d_read & ~d_write;
               w_mem_addr   = d_addr;
               w_mem_wdata  = d_wdata;
            end else if (w_grant_i) begin
               w_next_state = I_BUSY;
               w_mem_read   = 1'b1;
               w_mem_write  = 1'b0;
               w_mem_addr   = i_addr;
            end
         end
         I_BUSY, D_BUSY: begin
            if (mem_ready) begin
               w_next_state = RECOVER;
               w_mem_read   = 1'b0;
               w_mem_write  = 1'b0;
            end
         end
         // One dead cycle so a requester's late deassertion is not seen as a new request.
         RECOVER: w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_mem_read  <= 1'b0;
         r_mem_write <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
      end else begin
         r_state     <= w_next_state;
         r_mem_read  <= w_mem_read;
         r_mem_write <= w_mem_write;
         r_mem_addr  <= w_mem_addr;
         r_mem_wdata <= w_mem_wdata;
      end
   end

   assign mem_read  = r_mem_read;
   assign mem_write = r_mem_write;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;
   assign i_rdata   = mem_rdata;
   assign d_rdata   = mem_rdata;
   assign i_ready   = (r_state == I_BUSY) & mem_ready;
   assign d_ready   = (r_state == D_BUSY) & mem_ready;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: single I read, D write/read, stray ready, reset abort, tie-break.
module tb_mem_arbiter;

   localparam int ADDR_W = 28;
   localparam int DATA_W = 128;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              i_read, d_read, d_write, mem_ready;
   logic [ADDR_W-1:0] i_addr, d_addr, mem_addr;
   logic [DATA_W-1:0] d_wdata, mem_rdata, i_rdata, d_rdata, mem_wdata;
   logic              i_ready, d_ready, mem_read, mem_write;

   int total = 0;
   int bad   = 0;

   mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
      .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_ready(d_ready),
      .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   logic [3:0]        tie_d;
   logic              got;
   logic              exp_d;

   initial begin
`ifdef ARB_RR_EN
      tie_d = 4'b0101;
`else
      tie_d = 4'b1111;
`endif
      rst_n = 1'b0; i_read = 0; d_read = 0; d_write = 0; mem_ready = 0;
      i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
      #3;
      chk("rst_mem_read", mem_read, 0);
      chk("rst_mem_write", mem_write, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_ready", {i_ready, d_ready}, 0);
      chk("rdata_pass_i", i_rdata, mem_rdata);
      chk("rdata_pass_d", d_rdata, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
      @(posedge clk); #2 rst_n = 1'b1;

      // single I read: request cycle 0, ready cycle 5
      tick; i_read = 1; i_addr = 28'h0000012; #1;
      chk("i_c0_no_strobe", mem_read, 0);
      tick; #1;
      chk("i_c1_read", mem_read, 1);
      chk("i_c1_addr", mem_addr, 28'h0000012);
      chk("i_c1_noready", i_ready, 0);
      tick; i_addr = 28'h0000099; #1;
      tick; #1;
      chk("i_c3_addr_hold", mem_addr, 28'h0000012);
      tick; #1;
      chk("i_c4_read", mem_read, 1);
      tick; mem_ready = 1; #1;
      chk("i_c5_i_ready", i_ready, 1);
      chk("i_c5_d_ready", d_ready, 0);
      chk("i_c5_read", mem_read, 1);
      tick; mem_ready = 0; #1;
      chk("i_c6_read_off", mem_read, 0);
      chk("i_c6_i_ready", i_ready, 0);
      tick; i_read = 0; #1;
      chk("i_c7_recover_ignored", mem_read, 0);

      // stray ready in IDLE
      tick; mem_ready = 1; #1;
      chk("stray_ready", {i_ready, d_ready}, 0);
      tick; mem_ready = 0; d_write = 1; d_addr = 28'h0000345; d_wdata = {16{8'hA5}}; #1;
      chk("dw_c0_no_strobe", mem_write, 0);
      tick; d_addr = 28'h0000999; #1;
      chk("dw_write", mem_write, 1);
      chk("dw_no_read", mem_read, 0);
      chk("dw_addr", mem_addr, 28'h0000345);
      chk("dw_wdata", mem_wdata, {16{8'hA5}});
      tick; #1;
      chk("dw_addr_hold", mem_addr, 28'h0000345);
      tick; mem_ready = 1; #1;
      chk("dw_d_ready", d_ready, 1);
      chk("dw_i_ready", i_ready, 0);
      tick; mem_ready = 0; d_write = 0; d_read = 1; d_addr = 28'h0000346; #1;
      chk("dr_recover_write_off", mem_write, 0);
      chk("dr_recover_no_read", mem_read, 0);
      tick; #1;
      chk("dr_idle_no_read", mem_read, 0);
      tick; #1;
      chk("dr_read", mem_read, 1);
      chk("dr_no_write", mem_write, 0);
      chk("dr_addr", mem_addr, 28'h0000346);
      tick; mem_ready = 1; #1;
      chk("dr_d_ready", d_ready, 1);
      chk("dr_i_ready", i_ready, 0);

      // both d_read and d_write: write wins
      tick; mem_ready = 0; d_write = 1; d_addr = 28'h0000400; #1;
      tick; #1;
      tick; #1;
      chk("rw_write_wins", {mem_write, mem_read}, 2'b10);

      // reset during D_BUSY abandons the transaction
      rst_n = 0; #1;
      chk("abort_write_off", mem_write, 0);
      chk("abort_addr_zero", mem_addr, 0);
      mem_ready = 1; #1;
      chk("abort_no_d_ready", d_ready, 0);
      mem_ready = 0; d_write = 0; d_read = 0;
      tick; rst_n = 1; i_read = 1; i_addr = 28'h0000077; #1;
      chk("post_rst_no_strobe", mem_read, 0);
      tick; #1;
      chk("post_rst_read", mem_read, 1);
      chk("post_rst_addr", mem_addr, 28'h0000077);
      tick; i_read = 0; mem_ready = 1; #1;
      chk("post_rst_i_ready", i_ready, 1);

      // tie: both sides request continuously, ready three cycles after each strobe
      tick; mem_ready = 0; i_read = 1; d_read = 1; i_addr = 28'h0000111; d_addr = 28'h0000222; #1;
      for (int k = 0; k < 4; k++) begin
         got = 1'b0;
         for (int w = 0; w < 8 && !got; w++) begin
            tick; #1;
            if (mem_read) got = 1'b1;
         end
         chk("tie_strobe_seen", got, 1);
         exp_d = tie_d[k];
         chk("tie_grant_addr", mem_addr, exp_d ? 28'h0000222 : 28'h0000111);
         tick; tick; tick; mem_ready = 1; #1;
         chk("tie_d_ready", d_ready, exp_d);
         chk("tie_i_ready", i_ready, !exp_d);
         tick; mem_ready = 0; #1;
      end
      i_read = 0; d_read = 0;
      tick; tick;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
